crc4_frame_checker: RTL
=======================

Name: crc4_frame_checker

Overview:
- Sequential, bit-serial consumer of byte frames. Sits downstream of the CRC-4 generator in the link receive path.
- Recomputes the CRC-4 over each received frame, MSB-first, and compares it with the CRC nibble delivered alongside the frame's last byte.
- Reports pass/fail once per frame.
- Uses a valid/ready input handshake and a single-cycle result pulse.

Parameters:
- POLY, 4'h3, generator polynomial low bits (x^4 implicit); default is x^4+x+1.
- INIT, 4'h0, CRC register value at the start of every frame.
- MAX_LEN, 16, maximum legal frame length in bytes (1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte available.
- in_ready  output  1  checker can accept a byte this cycle.
- in_data  input  8  frame byte, MSB processed first.
- in_last  input  1  byte is the final byte of the frame.
- in_crc  input  4  expected CRC; sampled only on the accepted beat with in_last=1.
- res_valid  output  1  one-cycle result strobe.
- res_ok  output  1  CRC matched and length legal; meaningful only with res_valid.
- res_crc  output  4  computed CRC of the frame.
- res_len  output  8  byte count of the frame (saturates at 255).
- res_len_err  output  1  frame longer than MAX_LEN.
- busy  output  1  frame in progress (first byte accepted, result not yet issued).
- good_cnt  output  16  frames passed (optional feature).
- bad_cnt  output  16  frames failed (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCEPT; crc=INIT; byte counter=0.
  - in_ready=1 after reset deasserts.
  - res_valid=0, res_ok=0, res_crc=0, res_len=0, res_len_err=0, busy=0, counters=0.
- Reset asserted mid-frame discards the frame; no result is issued.
- FSM states: ACCEPT, SHIFT, DONE.
  - ACCEPT: in_ready=1.
    - On in_valid&&in_ready, register in_data and in_last (and in_crc if last).
    - Increment the saturating byte count, set busy, go to SHIFT with bit index 7.
  - SHIFT: in_ready=0. One bit per cycle for exactly 8 cycles, index 7 down to 0:
    - fb = crc[3] ^ bit
    - crc = {crc[2:0],1'b0} ^ (fb ? POLY : 4'h0)
    - After the index-0 cycle: go to DONE if the last flag is set, else go to ACCEPT.
  - DONE: in_ready=0. res_valid=1 for exactly one cycle, with:
    - res_crc=crc
    - res_len=count
    - res_len_err=(count>MAX_LEN)
    - res_ok=(crc==captured in_crc)&&!res_len_err
    - Next cycle: crc=INIT, count=0, busy=0, state=ACCEPT.
- Timing:
  - Throughput is 9 cycles per byte minimum.
  - res_valid is asserted 9 cycles after the edge accepting the last byte.
  - in_ready is high again the cycle after res_valid.
- Result outputs other than res_valid hold their values until the next DONE.
- in_valid while in_ready=0 is ignored. The upstream stage must hold in_data/in_last/in_crc until accepted.
- Single-byte frames (in_last on the first byte) are legal.
- Frames longer than 255 bytes: count stays at 255 and res_len_err=1.

Optional Feature:
- Macro CRC4_FRAME_STATS_EN.
- Defined: good_cnt increments on each res_valid with res_ok=1; bad_cnt increments on each res_valid with res_ok=0. Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: both ports are present but tied to 16'h0000, and no counter logic is synthesized.

Test Plan:
- Reset then idle -> in_ready=1, res_valid=0, busy=0, all result outputs 0.
- Frame {0x80} last, in_crc=0xE -> res_valid 9 cycles after accept, res_crc=0xE, res_ok=1, res_len=1, res_len_err=0.
- Frame {0x01,0x80}, in_crc=0x1 -> res_crc=0x1, res_ok=1, res_len=2. Also check in_ready is low for 8 cycles after each accept.
- Frame {0x01} with in_crc=0x2 -> res_crc=0x3, res_ok=0. With CRC4_FRAME_STATS_EN defined, bad_cnt=1 and good_cnt unchanged.
- 17 bytes of 0x00, last in_crc=0x0 -> res_crc=0x0, res_len=17, res_len_err=1, res_ok=0.
- rst_n pulsed low during SHIFT of the 2nd byte, then frame {0x80}/0xE -> no result for the aborted frame; new frame gives res_ok=1, res_len=1.

Source files
------------

// File: rtl/crc4_frame_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : crc4_frame_checker_if
// Description : Byte-stream handshake and result bundle for the CRC-4 frame
//               checker. The master drives frame bytes. The slave (checker)
//               returns ready, per-frame results and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
interface crc4_frame_checker_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [3:0]  in_crc;
    logic        res_valid;
    logic        res_ok;
    logic [3:0]  res_crc;
    logic [7:0]  res_len;
    logic        res_len_err;
    logic        busy;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    modport master (
        output in_valid, in_data, in_last, in_crc,
        input  in_ready, res_valid, res_ok, res_crc, res_len, res_len_err,
               busy, good_cnt, bad_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, in_crc,
        output in_ready, res_valid, res_ok, res_crc, res_len, res_len_err,
               busy, good_cnt, bad_cnt
    );
endinterface
`default_nettype wire

// File: rtl/crc4_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : crc4_frame_checker
// Description : Bit-serial CRC-4 checker for byte frames (MSB first). It
//               accepts one byte and then shifts it for 8 cycles. After the
//               last byte it issues a one-cycle result strobe with pass/fail,
//               the computed CRC and the frame length.
//               Optional pass/fail statistics are enabled by the macro
//               CRC4_FRAME_STATS_EN. Without the macro, good_cnt and bad_cnt
//               are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module crc4_frame_checker #(
    parameter logic [3:0] POLY    = 4'h3,
    parameter logic [3:0] INIT    = 4'h0,
    parameter int         MAX_LEN = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    crc4_frame_checker_if.slave  bus
);

    localparam logic [1:0] c_st_accept = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;
    localparam logic [7:0] c_max_len   = 8'(MAX_LEN);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_in_ready;
    logic       w_res_valid;

    logic [3:0] r_crc;
    logic [7:0] r_count;
    logic [2:0] r_bit_idx;
    logic [7:0] r_data;
    logic       r_last;
    logic [3:0] r_exp_crc;
    logic       r_busy;

    logic       r_res_ok;
    logic [3:0] r_res_crc;
    logic [7:0] r_res_len;
    logic       r_res_len_err;

    logic       w_bit;
    logic       w_fb;
    logic [3:0] w_crc_step;
    logic       w_fin_len_err;

    // One LFSR step on the current message bit
    assign w_bit         = r_data[r_bit_idx];
    assign w_fb          = r_crc[3] ^ w_bit;
    assign w_crc_step    = {r_crc[2:0], 1'b0} ^ (w_fb ? POLY : 4'h0);
    assign w_fin_len_err = (r_count > c_max_len);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_accept;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake/strobe outputs
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            c_st_accept: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = c_st_shift;
                end
            end
            c_st_shift: begin
                if (r_bit_idx == 3'd0) begin
                    w_state_nxt = r_last ? c_st_done : c_st_accept;
                end
            end
            c_st_done: begin
                w_res_valid = 1'b1;
                w_state_nxt = c_st_accept;
            end
            default: begin
                w_state_nxt = c_st_accept;
            end
        endcase
    end

    // Datapath: byte capture, CRC shifting, and result capture on the final bit.
    // The result is latched as the final bit shifts in. It is therefore stable
    // during the DONE strobe and holds until the next frame finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc         <= INIT;
            r_count       <= 8'd0;
            r_bit_idx     <= 3'd0;
            r_data        <= 8'd0;
            r_last        <= 1'b0;
            r_exp_crc     <= 4'd0;
            r_busy        <= 1'b0;
            r_res_ok      <= 1'b0;
            r_res_crc     <= 4'd0;
            r_res_len     <= 8'd0;
            r_res_len_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_accept: begin
                    if (bus.in_valid) begin
                        r_data    <= bus.in_data;
                        r_last    <= bus.in_last;
                        if (bus.in_last) begin
                            r_exp_crc <= bus.in_crc;
                        end
                        r_count   <= (r_count == 8'hFF) ? 8'hFF : r_count + 8'd1;
                        r_busy    <= 1'b1;
                        r_bit_idx <= 3'd7;
                    end
                end
                c_st_shift: begin
                    r_crc     <= w_crc_step;
                    r_bit_idx <= r_bit_idx - 3'd1;
                    if ((r_bit_idx == 3'd0) && r_last) begin
                        r_res_crc     <= w_crc_step;
                        r_res_len     <= r_count;
                        r_res_len_err <= w_fin_len_err;
                        r_res_ok      <= (w_crc_step == r_exp_crc) && !w_fin_len_err;
                    end
                end
                c_st_done: begin
                    r_crc   <= INIT;
                    r_count <= 8'd0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_crc <= INIT;
                end
            endcase
        end
    end

`ifdef CRC4_FRAME_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    // Saturating pass/fail counters, stepped once per result strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good_cnt <= 16'h0000;
            r_bad_cnt  <= 16'h0000;
        end else if (w_res_valid) begin
            if (r_res_ok) begin
                if (r_good_cnt != 16'hFFFF) begin
                    r_good_cnt <= r_good_cnt + 16'd1;
                end
            end else begin
                if (r_bad_cnt != 16'hFFFF) begin
                    r_bad_cnt <= r_bad_cnt + 16'd1;
                end
            end
        end
    end

    assign bus.good_cnt = r_good_cnt;
    assign bus.bad_cnt  = r_bad_cnt;
`else
    assign bus.good_cnt = 16'h0000;
    assign bus.bad_cnt  = 16'h0000;
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_ok      = r_res_ok;
    assign bus.res_crc     = r_res_crc;
    assign bus.res_len     = r_res_len;
    assign bus.res_len_err = r_res_len_err;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire
